// File: rtl/add_sync.sv
// Registered unsigned adder: sum is a+b one clock after a and b are sampled.
// The carry-out is kept as the MSB, so the result never wraps.
module add_sync #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH:0]   RESET_SUM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] sum_q;
  logic [WIDTH:0] sum_d;

  // Operands are widened first so the carry lands in the top bit.
  always_comb begin
    sum_d = {1'b0, a} + {1'b0, b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= RESET_SUM;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_add_sync.sv
// Directed and random checks of add_sync against an arithmetic reference
// that predicts each registered sum one edge after its operands are applied.
module tb_add_sync;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   sum;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  add_sync #(.WIDTH(W), .RESET_SUM('0)) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .sum(sum)
  );

  task automatic check(input string tag, input logic [W:0] expected);
    compared++;
    assert (sum === expected) else begin
      mismatched++;
      $error("FAIL %s: sum=%0d expected=%0d", tag, sum, expected);
    end
  endtask

  // Apply inputs, take one rising edge, then check the registered result.
  task automatic step(input logic r, input int av, input int bv, input string tag);
    int expected;
    rst = r;
    a   = W'(av);
    b   = W'(bv);
    expected = r ? 0 : av + bv;
    @(posedge clk);
    #1;
    check(tag, (W+1)'(expected));
    $display("step %s: rst=%0d a=%0d b=%0d sum=%0d", tag, r, av, bv, sum);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   av;
    int   bv;
    int   exp_q[$];
    int   expected;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    #1;

    // Reset held for two edges with nonzero operands, then first add.
    step(1'b1, 9, 6, "reset_edge1");
    step(1'b1, 9, 6, "reset_edge2");
    step(1'b0, 9, 6, "first_add");

    // Mid-cycle operand change must not reach sum before the next edge.
    step(1'b0, 5, 3, "add_5_3");
    #5;
    a = 4'd7;
    #1;
    check("hold_mid_cycle", 5'd8);
    @(posedge clk);
    #1;
    check("after_change", 5'd10);
    $display("step after_change: a=7 b=3 sum=%0d", sum);

    // Corners, including carry-out and the maximum result.
    step(1'b0, 0, 0, "zero");
    step(1'b0, 15, 1, "carry");
    step(1'b0, 15, 15, "max");

    // Back-to-back pairs on consecutive edges.
    step(1'b0, 1, 2, "b2b_1_2");
    step(1'b0, 3, 4, "b2b_3_4");
    step(1'b0, 8, 8, "b2b_8_8");
    step(1'b0, 12, 9, "b2b_12_9");

    // Reset raised between edges must not clear sum until the next edge.
    step(1'b0, 10, 5, "pre_reset");
    rst = 1'b1;
    #3;
    check("reset_not_async", 5'd15);
    @(posedge clk);
    #1;
    check("reset_wins", 5'd0);
    $display("step reset_wins: rst=1 a=10 b=5 sum=%0d", sum);
    step(1'b0, 10, 5, "reset_release");

    // Random pairs against a one-edge-delayed reference queue.
    for (int i = 0; i < 1000; i++) begin
      av = int'($urandom_range(15, 0));
      bv = int'($urandom_range(15, 0));
      a  = W'(av);
      b  = W'(bv);
      exp_q.push_back(av + bv);
      @(posedge clk);
      #1;
      expected = exp_q.pop_front();
      check("random", (W+1)'(expected));
      $display("random %0d: a=%0d b=%0d sum=%0d", i, av, bv, sum);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
